// File: rtl/vpu_lane_issue_ctrl.sv
// vpu_lane_issue_ctrl
//   Issue controller for one VPU lane. Accepts one encoded FP op at a time from dispatch,
//   decodes it to a one-hot op vector, pulses lane_start_o for one cycle, then waits for
//   lane_done_i under a timeout watchdog. Every accepted request yields exactly one entry
//   in a small response FIFO: lane data, or an error for an illegal op or a timeout.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid_i/req_ready_o request handshake; req_op_i encoded op, req_operand_i operands
//   lane_start_o            one-cycle start pulse to the lane
//   lane_op_o               one-hot op, held from ISSUE through WAIT, 0 in IDLE
//   lane_operand_o          latched operands, held from ISSUE through WAIT, 0 in IDLE
//   lane_done_i/lane_dout_i lane completion and result
//   rsp_valid_o/rsp_ready_i response handshake; rsp_data_o result, rsp_err_o error flag
//   busy_o                  an op is in flight or a response is queued

module vpu_lane_issue_ctrl #(
    parameter int unsigned OPERAND_WIDTH = 32,
    parameter int unsigned SRC_CNT       = 3,
    parameter int unsigned NUM_OPS       = 12,
    parameter int unsigned OP_W          = 4,
    parameter int unsigned RSP_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYC   = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [OP_W-1:0]                  req_op_i,
    input  logic [SRC_CNT*OPERAND_WIDTH-1:0] req_operand_i,
    output logic                             lane_start_o,
    output logic [NUM_OPS-1:0]               lane_op_o,
    output logic [SRC_CNT*OPERAND_WIDTH-1:0] lane_operand_o,
    input  logic                             lane_done_i,
    input  logic [OPERAND_WIDTH-1:0]         lane_dout_i,
    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic [OPERAND_WIDTH-1:0]         rsp_data_o,
    output logic                             rsp_err_o,
    output logic                             busy_o
);

    localparam int unsigned OpndW = SRC_CNT * OPERAND_WIDTH;
    localparam int unsigned PtrW  = (RSP_DEPTH > 2) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned TmoW  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned EntW  = OPERAND_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e                   state_q, state_d;
    logic                     start_q, start_d;
    logic [NUM_OPS-1:0]       op_q, op_d;
    logic [OpndW-1:0]         opnd_q, opnd_d;
    logic [TmoW-1:0]          tmo_q, tmo_d;
    logic [EntW-1:0]          mem_q [RSP_DEPTH];
    logic [EntW-1:0]          mem_d [RSP_DEPTH];
    logic [PtrW-1:0]          wptr_q, wptr_d;
    logic [PtrW-1:0]          rptr_q, rptr_d;
    logic [CntW-1:0]          count_q, count_d;

    logic                     fifo_full, fifo_empty;
    logic                     req_fire, op_legal;
    logic [NUM_OPS-1:0]       op_dec;
    logic                     push, pop, push_err;
    logic [OPERAND_WIDTH-1:0] push_data;

    assign fifo_full  = (count_q == CntW'(RSP_DEPTH));
    assign fifo_empty = (count_q == '0);

    // Gated by rst_n so dispatch never sees ready while the block is held in reset.
    assign req_ready_o = rst_n && (state_q == StIdle) && !fifo_full;
    assign req_fire    = req_valid_i && req_ready_o;
    assign op_legal    = (32'(req_op_i) < NUM_OPS);

    always_comb begin
        op_dec = '0;
        for (int unsigned i = 0; i < NUM_OPS; i++) begin
            op_dec[i] = (32'(req_op_i) == i);
        end
    end

    // Controller next state and FIFO push request.
    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        op_d      = op_q;
        opnd_d    = opnd_q;
        tmo_d     = tmo_q;
        push      = 1'b0;
        push_err  = 1'b0;
        push_data = '0;
        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    if (op_legal) begin
                        op_d    = op_dec;
                        opnd_d  = req_operand_i;
                        start_d = 1'b1;
                        state_d = StIssue;
                    end else begin
                        push     = 1'b1;
                        push_err = 1'b1;
                    end
                end
            end
            StIssue: begin
                tmo_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                tmo_d = tmo_q + TmoW'(1);
                // Done takes priority over a timeout landing in the same cycle.
                if (lane_done_i) begin
                    push      = 1'b1;
                    push_data = lane_dout_i;
                end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                    push     = 1'b1;
                    push_err = 1'b1;
                end
                if (push) begin
                    op_d    = '0;
                    opnd_d  = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                op_d    = '0;
                opnd_d  = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Response FIFO. A push can never hit a full FIFO: requests are only taken with a
    // free slot and only one op is ever in flight.
    assign pop = !fifo_empty && rsp_ready_i;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[wptr_q] = {push_err, push_data};
            wptr_d        = wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            start_q <= 1'b0;
            op_q    <= '0;
            opnd_q  <= '0;
            tmo_q   <= '0;
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            tmo_q   <= tmo_d;
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign lane_start_o   = start_q;
    assign lane_op_o      = op_q;
    assign lane_operand_o = opnd_q;

    // Stale entries stay in memory after a pop; mask the head when empty.
    assign rsp_valid_o = !fifo_empty;
    assign rsp_data_o  = fifo_empty ? '0 : mem_q[rptr_q][OPERAND_WIDTH-1:0];
    assign rsp_err_o   = fifo_empty ? 1'b0 : mem_q[rptr_q][OPERAND_WIDTH];
    assign busy_o      = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_vpu_lane_issue_ctrl.sv
module tb_vpu_lane_issue_ctrl;

    localparam int W = 32;
    localparam int NOPS = 12;
    localparam int TMO = 64;

    logic          clk;
    logic          rst_n;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [3:0]    req_op_i;
    logic [95:0]   req_operand_i;
    logic          lane_start_o;
    logic [11:0]   lane_op_o;
    logic [95:0]   lane_operand_o;
    logic          lane_done_i;
    logic [W-1:0]  lane_dout_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [W-1:0]  rsp_data_o;
    logic          rsp_err_o;
    logic          busy_o;

    int            n_checks = 0;
    int            n_errors = 0;
    bit            mon_en = 0;
    bit            rnd_ready = 0;
    logic [W:0]    exp_q[$];

    vpu_lane_issue_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_operand_i  (req_operand_i),
        .lane_start_o   (lane_start_o),
        .lane_op_o      (lane_op_o),
        .lane_operand_o (lane_operand_o),
        .lane_done_i    (lane_done_i),
        .lane_dout_i    (lane_dout_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_data_o     (rsp_data_o),
        .rsp_err_o      (rsp_err_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    // Advance one clock; when the scoreboard is on, a response handshake seen before the
    // edge is compared with the oldest expected response.
    task automatic step();
        logic       hs;
        logic [W:0] got;
        logic [W:0] e;
        if (rnd_ready) rsp_ready_i = 1'($urandom_range(0, 1));
        hs  = rsp_valid_o && rsp_ready_i;
        got = {rsp_err_o, rsp_data_o};
        @(posedge clk);
        #1;
        if (mon_en && hs) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard_extra: got err=%0b data=%h, required no response",
                         got[W], got[W-1:0]);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_errors++;
                    $display("FAIL scoreboard_rsp: got err=%0b data=%h, required err=%0b data=%h",
                             got[W], got[W-1:0], e[W], e[W-1:0]);
                end
            end
        end
    endtask

    // Drive one request and play the lane. lat = WAIT cycle in which done is raised
    // (1..TMO), anything else = lane never answers. Returns the response the rules imply.
    task automatic issue_op(input logic [3:0] op, input logic [95:0] opnd, input int lat,
                            input logic [W-1:0] dout, input bit chk_empty, input bit stray,
                            output logic [W:0] exp_rsp);
        int          guard;
        int          nwait;
        logic [11:0] oh;
        bit          answers;
        guard = 0;
        answers = (lat >= 1) && (lat <= TMO);
        req_valid_i = 1'b1;
        req_op_i = op;
        req_operand_i = opnd;
        while (req_ready_o !== 1'b1 && guard < 300) begin
            step();
            guard++;
        end
        if (guard >= 300) begin
            n_checks++;
            n_errors++;
            $display("FAIL req_ready_wait: got ready=%0b, required 1 within 300 cycles", req_ready_o);
        end
        step();
        req_valid_i = 1'b0;
        req_op_i = 4'($urandom);
        req_operand_i = {$urandom, $urandom, $urandom};
        if (32'(op) >= NOPS) begin
            n_checks++;
            if (lane_start_o !== 1'b0 || lane_op_o !== 12'h0) begin
                n_errors++;
                $display("FAIL illegal_no_start: got start=%0b op=%h, required 0 000",
                         lane_start_o, lane_op_o);
            end
            n_checks++;
            if (rsp_valid_o !== 1'b1) begin
                n_errors++;
                $display("FAIL illegal_rsp_valid: got %0b, required 1", rsp_valid_o);
            end
            exp_rsp = {1'b1, 32'h0};
            return;
        end
        oh = '0;
        oh[op] = 1'b1;
        lane_done_i = stray;
        lane_dout_i = $urandom;
        n_checks++;
        if (lane_start_o !== 1'b1 || lane_op_o !== oh || lane_operand_o !== opnd) begin
            n_errors++;
            $display("FAIL issue_cycle: got start=%0b op=%h opnd=%h, required 1 %h %h",
                     lane_start_o, lane_op_o, lane_operand_o, oh, opnd);
        end
        if (chk_empty) begin
            n_checks++;
            if (rsp_valid_o !== 1'b0) begin
                n_errors++;
                $display("FAIL issue_no_rsp: got rsp_valid=%0b, required 0", rsp_valid_o);
            end
        end
        nwait = answers ? lat : TMO;
        for (int w = 1; w <= nwait; w++) begin
            step();
            n_checks++;
            if (lane_start_o !== 1'b0 || lane_op_o !== oh || lane_operand_o !== opnd ||
                req_ready_o !== 1'b0 || busy_o !== 1'b1) begin
                n_errors++;
                $display("FAIL wait_hold w=%0d: got start=%0b op=%h ready=%0b busy=%0b, required 0 %h 0 1",
                         w, lane_start_o, lane_op_o, req_ready_o, busy_o, oh);
            end
            if (chk_empty && rsp_valid_o !== 1'b0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wait_no_rsp w=%0d: got rsp_valid=1, required 0", w);
            end
            lane_done_i = (w == lat);
            lane_dout_i = (w == lat) ? dout : $urandom;
        end
        step();
        lane_done_i = 1'b0;
        n_checks++;
        if (lane_start_o !== 1'b0 || lane_op_o !== 12'h0 || lane_operand_o !== 96'h0 ||
            rsp_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL return_idle: got start=%0b op=%h opnd=%h rsp_valid=%0b, required 0 000 0 1",
                     lane_start_o, lane_op_o, lane_operand_o, rsp_valid_o);
        end
        exp_rsp = answers ? {1'b0, dout} : {1'b1, 32'h0};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid_i = 1'b1;
        req_op_i = 4'd3;
        req_operand_i = '1;
        lane_done_i = 1'b1;
        lane_dout_i = 32'hFFFF_FFFF;
        rsp_ready_i = 1'b1;
        step();
        step();
        n_checks++;
        if (lane_start_o !== 1'b0 || lane_op_o !== 12'h0 || lane_operand_o !== 96'h0 ||
            rsp_valid_o !== 1'b0 || rsp_data_o !== 32'h0 || rsp_err_o !== 1'b0 ||
            busy_o !== 1'b0 || req_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got start=%0b op=%h val=%0b busy=%0b ready=%0b, required all 0",
                     lane_start_o, lane_op_o, rsp_valid_o, busy_o, req_ready_o);
        end
        req_valid_i = 1'b0;
        lane_done_i = 1'b0;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: got ready=%0b busy=%0b, required 1 0", req_ready_o, busy_o);
        end
    endtask

    task automatic test_basic();
        logic [W:0] e;
        rsp_ready_i = 1'b1;
        issue_op(4'd3, {32'hDEAD_BEEF, 32'h4000_0000, 32'h3F80_0000}, 4, 32'h4000_0000, 1'b1,
                 1'b0, e);
        n_checks++;
        if (rsp_data_o !== 32'h4000_0000 || rsp_err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_rsp: got err=%0b data=%h, required 0 40000000", rsp_err_o, rsp_data_o);
        end
        step();
        n_checks++;
        if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_drain: got val=%0b busy=%0b ready=%0b, required 0 0 1",
                     rsp_valid_o, busy_o, req_ready_o);
        end
    endtask

    task automatic test_illegal();
        logic [W:0] e;
        rsp_ready_i = 1'b0;
        issue_op(4'd13, {3{32'h1234_5678}}, 2, 32'h0, 1'b1, 1'b0, e);
        n_checks++;
        if (rsp_err_o !== 1'b1 || rsp_data_o !== 32'h0 || busy_o !== 1'b1 || req_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL illegal_rsp: got err=%0b data=%h busy=%0b ready=%0b, required 1 0 1 1",
                     rsp_err_o, rsp_data_o, busy_o, req_ready_o);
        end
        rsp_ready_i = 1'b1;
        step();
        n_checks++;
        if (rsp_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal_drain: got rsp_valid=%0b, required 0", rsp_valid_o);
        end
    endtask

    task automatic test_timeout();
        logic [W:0] e;
        rsp_ready_i = 1'b0;
        issue_op(4'd9, {3{32'hA5A5_5A5A}}, 0, 32'h0, 1'b1, 1'b0, e);
        n_checks++;
        if (rsp_err_o !== 1'b1 || rsp_data_o !== 32'h0 || req_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_rsp: got err=%0b data=%h ready=%0b, required 1 0 1",
                     rsp_err_o, rsp_data_o, req_ready_o);
        end
        lane_done_i = 1'b1;
        lane_dout_i = 32'h0000_1234;
        step();
        lane_done_i = 1'b0;
        step();
        rsp_ready_i = 1'b1;
        step();
        n_checks++;
        if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL stray_done_ignored: got val=%0b busy=%0b, required 0 0", rsp_valid_o, busy_o);
        end
    endtask

    task automatic test_coincide();
        logic [W:0] e;
        rsp_ready_i = 1'b1;
        issue_op(4'd10, {3{32'h0BAD_F00D}}, TMO, 32'hCAFE_F00D, 1'b1, 1'b1, e);
        n_checks++;
        if (rsp_err_o !== 1'b0 || rsp_data_o !== 32'hCAFE_F00D) begin
            n_errors++;
            $display("FAIL done_beats_timeout: got err=%0b data=%h, required 0 cafef00d",
                     rsp_err_o, rsp_data_o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [W:0] e;
        rsp_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            issue_op(4'(k), {$urandom, $urandom, $urandom}, 2, 32'h1000 + 32'(k), k == 0, 1'b0, e);
        end
        n_checks++;
        if (req_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL full_not_ready: got ready=%0b busy=%0b, required 0 1", req_ready_o, busy_o);
        end
        step();
        n_checks++;
        if (rsp_data_o !== 32'h1000 || req_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL full_hold: got data=%h ready=%0b, required 00001000 0", rsp_data_o, req_ready_o);
        end
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_data_o !== 32'h1000 + 32'(k)) begin
                n_errors++;
                $display("FAIL drain_order k=%0d: got val=%0b err=%0b data=%h, required 1 0 %h",
                         k, rsp_valid_o, rsp_err_o, rsp_data_o, 32'h1000 + 32'(k));
            end
            step();
            if (k == 0) begin
                n_checks++;
                if (req_ready_o !== 1'b1) begin
                    n_errors++;
                    $display("FAIL ready_reassert: got %0b, required 1", req_ready_o);
                end
            end
        end
        n_checks++;
        if (rsp_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_empty: got rsp_valid=%0b, required 0", rsp_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [W:0] e;
        rsp_ready_i = 1'b0;
        issue_op(4'd1, {3{32'h1111_1111}}, 1, 32'h0000_00AA, 1'b1, 1'b0, e);
        issue_op(4'd2, {3{32'h2222_2222}}, 1, 32'h0000_00BB, 1'b0, 1'b0, e);
        req_valid_i = 1'b1;
        req_op_i = 4'd5;
        req_operand_i = {3{32'h3333_3333}};
        step();
        req_valid_i = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (lane_start_o !== 1'b0 || lane_op_o !== 12'h0 || lane_operand_o !== 96'h0 ||
            rsp_valid_o !== 1'b0 || rsp_data_o !== 32'h0 || rsp_err_o !== 1'b0 ||
            busy_o !== 1'b0 || req_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: got op=%h val=%0b busy=%0b ready=%0b, required all 0",
                     lane_op_o, rsp_valid_o, busy_o, req_ready_o);
        end
        lane_done_i = 1'b1;
        lane_dout_i = 32'h0000_0777;
        step();
        rst_n = 1'b1;
        step();
        lane_done_i = 1'b0;
        n_checks++;
        if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_release: got val=%0b busy=%0b ready=%0b, required 0 0 1",
                     rsp_valid_o, busy_o, req_ready_o);
        end
    endtask

    task automatic test_random();
        logic [W:0]  e;
        logic [3:0]  op;
        int          r;
        int          lat;
        int          guard;
        exp_q.delete();
        mon_en = 1'b1;
        rnd_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            r = int'($urandom_range(0, 15));
            lat = (r == 0) ? 0 : (r == 1) ? TMO : int'($urandom_range(1, 6));
            issue_op(op, {$urandom, $urandom, $urandom}, lat, $urandom, 1'b0,
                     1'($urandom_range(0, 1)), e);
            exp_q.push_back(e);
            repeat ($urandom_range(0, 2)) step();
        end
        rnd_ready = 1'b0;
        rsp_ready_i = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            step();
            guard++;
        end
        step();
        n_checks++;
        if (exp_q.size() != 0 || rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL random_drain: got pending=%0d val=%0b busy=%0b, required 0 0 0",
                     exp_q.size(), rsp_valid_o, busy_o);
        end
        mon_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_timeout();
        test_coincide();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vpu_lane_issue_ctrl.md
Name: vpu_lane_issue_ctrl

Overview:
- Sequences one VPU lane datapath: accepts encoded FP op requests with operands and converts each into a one-hot op vector plus a single-cycle start pulse.
- Waits for the lane's done, guarded by a timeout watchdog, then queues the result in a response FIFO with valid/ready output.
- Sits between the VPU dispatch stage and the lane; one op is outstanding at a time.

Parameters:
- OPERAND_WIDTH, 32, width of each operand and of the result.
- SRC_CNT, 3, number of source operands.
- NUM_OPS, 12, number of lane ops. Encoding: 0 add2, 1 sub, 2 add3, 3 mul, 4 div, 5 max2, 6 max3, 7 avg2, 8 avg3, 9 sqrt, 10 exp, 11 recip.
- OP_W, 4, width of the encoded op field.
- RSP_DEPTH, 4, response FIFO depth (power of 2, ≥2).
- TIMEOUT_CYC, 64, maximum cycles spent in WAIT before an error response.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_op_i  in  OP_W  encoded op.
- req_operand_i  in  SRC_CNT*OPERAND_WIDTH  operands; operand k at bits [k*OPERAND_WIDTH +: OPERAND_WIDTH].
- lane_start_o  out  1  one-cycle start pulse to the lane.
- lane_op_o  out  NUM_OPS  one-hot op vector to the lane.
- lane_operand_o  out  SRC_CNT*OPERAND_WIDTH  latched operands to the lane.
- lane_done_i  in  1  lane completion.
- lane_dout_i  in  OPERAND_WIDTH  lane result, valid with done.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_data_o  out  OPERAND_WIDTH  result.
- rsp_err_o  out  1  1 = illegal op or timeout.
- busy_o  out  1  state!=IDLE or FIFO non-empty.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; FIFO empty; timeout counter=0.
  - lane_start_o=0, lane_op_o=0, lane_operand_o=0.
  - rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, busy_o=0, req_ready_o=0 while in reset.
  - Reset mid-operation discards the in-flight op and all queued responses; a late lane_done_i after reset is ignored.
- req_ready_o = (state==IDLE) && !fifo_full. Purely combinational from state and FIFO count; no dependence on req_valid_i.
- IDLE:
  - On handshake with req_op_i < NUM_OPS: latch the op (one-hot decode) and operands, go to ISSUE.
  - On handshake with req_op_i >= NUM_OPS: push {err=1, data=0} into the FIFO and stay in IDLE; the lane is not touched.
- ISSUE (exactly 1 cycle): lane_start_o=1, clear the timeout counter, go to WAIT.
- lane_op_o and lane_operand_o hold their latched values from ISSUE through the end of WAIT, and are 0 in IDLE.
- WAIT:
  - Counter increments each cycle.
  - On lane_done_i=1: push {err=0, data=lane_dout_i}, go to IDLE.
  - Otherwise, when counter==TIMEOUT_CYC-1: push {err=1, data=0}, go to IDLE.
  - If done and timeout coincide, done wins (err=0).
- lane_done_i outside WAIT (including the ISSUE cycle) is ignored.
- The FIFO cannot overflow: a request is only accepted when a slot is free and at most one op is in flight, so the push at completion is always guaranteed.
- FIFO:
  - rsp_valid_o = !empty; rsp_data_o/rsp_err_o show the head entry and hold stable while valid&&!ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pointers wrap modulo RSP_DEPTH.
- Latency:
  - Accept at edge T; lane_start_o high during cycle T+1.
  - Done sampled in cycle T+1+L (L ≥ 1); rsp_valid_o high in the following cycle.
  - Minimum accept-to-response is 3 cycles.
  - Illegal op: rsp_valid_o is high in the cycle after the accept.
- Back-to-back: the next request can be accepted the cycle after the return to IDLE, provided the FIFO is not full.

Test Plan:
- Reset, then req op=3 (mul), operands {0x3F800000, 0x40000000, x}; lane model returns done + 0x40000000 after 4 cycles → lane_start_o one pulse, lane_op_o=12'h008, rsp_data_o=0x40000000, rsp_err_o=0, latency 6 cycles.
- req_op_i=13 → no lane_start_o; next cycle rsp_valid_o=1, rsp_err_o=1, rsp_data_o=0.
- Lane never asserts done, TIMEOUT_CYC=64 → after 64 WAIT cycles rsp_err_o=1, data 0, state IDLE; a later stray lane_done_i is ignored (FIFO count unchanged).
- rsp_ready_i=0, issue 4 ops (done latency 2) → req_ready_o drops after the 4th push; raise rsp_ready_i → responses drain in order and req_ready_o re-asserts.
- Done and timeout in the same cycle → rsp_err_o=0 with lane data.
- Assert rst_n=0 during WAIT with 2 entries queued → all outputs 0 immediately; after release busy_o=0 and req_ready_o=1.
